// File: rtl/clock_pkg.sv
// Shared types and default constants for the 7-segment chain serializer.
package clock_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD     = 3'd1,
    SHIFT_LO = 3'd2,
    SHIFT_HI = 3'd3,
    LATCH    = 3'd4,
    DONE     = 3'd5
  } state_t;

  localparam int unsigned DEF_NUM_DIGITS   = 6;
  localparam int unsigned DEF_SEG_BITS     = 8;
  localparam int unsigned DEF_CLK_DIV      = 4;
  localparam int unsigned DEF_LATCH_CYCLES = 2;

  // Registered serializer outputs, updated together each cycle.
  typedef struct packed {
    logic serial_data;
    logic serial_clk;
    logic serial_latch;
    logic busy;
    logic done;
  } ser_out_t;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/seg7_chain_serializer_if.sv
// Control, pattern and serial-output bundle of the 7-segment chain serializer.
interface seg7_chain_serializer_if
  import clock_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = DEF_NUM_DIGITS,
  parameter int unsigned SEG_BITS   = DEF_SEG_BITS
);
  logic                           i_en;
  logic                           i_start;
  logic [NUM_DIGITS*SEG_BITS-1:0] i_segments;
  logic [NUM_DIGITS-1:0]          i_blank;
  logic                           i_invert;
  logic                           o_serial_data;
  logic                           o_serial_clk;
  logic                           o_serial_latch;
  logic                           o_busy;
  logic                           o_done;

  modport master (
    output i_en, i_start, i_segments, i_blank, i_invert,
    input  o_serial_data, o_serial_clk, o_serial_latch, o_busy, o_done
  );

  modport slave (
    input  i_en, i_start, i_segments, i_blank, i_invert,
    output o_serial_data, o_serial_clk, o_serial_latch, o_busy, o_done
  );
endinterface

// File: rtl/seg7_tick_gen.sv
// Loadable, enable-gated down-counter; tc_c flags terminal count (zero).
module seg7_tick_gen #(
  parameter int unsigned WIDTH = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             tc_c
);
  logic [WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (en) begin
      if (load) begin
        count <= load_value;
      end else if (count != '0) begin
        count <= count - WIDTH'(1);
      end
    end
  end

  assign tc_c = (count == '0);
endmodule

// File: rtl/seg7_chain_serializer.sv
// Serializes per-digit segment patterns MSB first into an external shift-register
// chain, then pulses the storage latch.
module seg7_chain_serializer
  import clock_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = DEF_NUM_DIGITS,
  parameter int unsigned SEG_BITS     = DEF_SEG_BITS,
  parameter int unsigned CLK_DIV      = DEF_CLK_DIV,
  parameter int unsigned LATCH_CYCLES = DEF_LATCH_CYCLES
) (
  input logic              i_clk,
  input logic              i_reset,
  seg7_chain_serializer_if.slave bus
);
  localparam int unsigned TOTAL    = NUM_DIGITS * SEG_BITS;
  localparam int unsigned BIT_W    = $clog2(TOTAL + 1);
  localparam int unsigned TICK_MAX = max_u(CLK_DIV, LATCH_CYCLES);
  localparam int unsigned TICK_W   = $clog2(TICK_MAX + 1);

  state_t              state, state_d;
  logic [TOTAL-1:0]    shreg, shreg_d, masked, frame;
  logic [BIT_W-1:0]    bit_cnt, bit_cnt_d;
  logic                tick_load, tick_tc;
  logic [TICK_W-1:0]   tick_value;
  logic                shifting;
  ser_out_t            out_q, out_d;

  // Blanked digits are zeroed before the polarity inversion.
  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
    assign masked[k*SEG_BITS +: SEG_BITS] =
      bus.i_blank[k] ? '0 : bus.i_segments[k*SEG_BITS +: SEG_BITS];
  end
  assign frame = masked ^ {TOTAL{bus.i_invert}};

  seg7_tick_gen #(.WIDTH(TICK_W)) u_tick (
    .clk        (i_clk),
    .reset      (i_reset),
    .en         (bus.i_en),
    .load       (tick_load),
    .load_value (tick_value),
    .tc_c       (tick_tc)
  );

  // Next-state, datapath and output decode; i_en low holds everything.
  always_comb begin
    state_d    = state;
    shreg_d    = shreg;
    bit_cnt_d  = bit_cnt;
    tick_load  = 1'b0;
    tick_value = '0;
    out_d      = '0;
    if (bus.i_en) begin
      case (state)
        IDLE: begin
          if (bus.i_start) state_d = LOAD;
        end
        LOAD: begin
          shreg_d    = frame;
          bit_cnt_d  = BIT_W'(TOTAL);
          tick_load  = 1'b1;
          tick_value = TICK_W'(CLK_DIV - 1);
          state_d    = SHIFT_LO;
        end
        SHIFT_LO: begin
          if (tick_tc) begin
            tick_load  = 1'b1;
            tick_value = TICK_W'(CLK_DIV - 1);
            state_d    = SHIFT_HI;
          end
        end
        SHIFT_HI: begin
          if (tick_tc) begin
            shreg_d   = shreg << 1;
            bit_cnt_d = bit_cnt - BIT_W'(1);
            tick_load = 1'b1;
            if (bit_cnt == BIT_W'(1)) begin
              tick_value = TICK_W'(LATCH_CYCLES - 1);
              state_d    = LATCH;
            end else begin
              tick_value = TICK_W'(CLK_DIV - 1);
              state_d    = SHIFT_LO;
            end
          end
        end
        LATCH: begin
          if (tick_tc) state_d = DONE;
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
    shifting           = (state_d == SHIFT_LO) || (state_d == SHIFT_HI);
    out_d.serial_data  = shifting && shreg_d[TOTAL-1];
    out_d.serial_clk   = (state_d == SHIFT_HI);
    out_d.serial_latch = (state_d == LATCH);
    out_d.busy         = (state_d != IDLE);
    out_d.done         = (state_d == DONE);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state   <= IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
      out_q   <= '0;
    end else begin
      state   <= state_d;
      shreg   <= shreg_d;
      bit_cnt <= bit_cnt_d;
      out_q   <= out_d;
    end
  end

  assign bus.o_serial_data  = out_q.serial_data;
  assign bus.o_serial_clk   = out_q.serial_clk;
  assign bus.o_serial_latch = out_q.serial_latch;
  assign bus.o_busy         = out_q.busy;
  assign bus.o_done         = out_q.done;
endmodule

// File: tb/tb_seg7_chain_serializer.sv
// Bench for seg7_chain_serializer: default-size instance with a stream scoreboard
// plus a minimal 1-digit instance.
module tb_seg7_chain_serializer;
  localparam logic [47:0] PAT = 48'hFC60DAF266B6;

  logic clk;
  logic reset;
  int   tests;
  int   fails;
  logic [47:0] exp_q[$];

  seg7_chain_serializer_if #(.NUM_DIGITS(6), .SEG_BITS(8)) bus_a ();
  seg7_chain_serializer_if #(.NUM_DIGITS(1), .SEG_BITS(8)) bus_b ();

  seg7_chain_serializer #(.NUM_DIGITS(6), .SEG_BITS(8), .CLK_DIV(4), .LATCH_CYCLES(2)) dut_a (
    .i_clk(clk), .i_reset(reset), .bus(bus_a)
  );
  seg7_chain_serializer #(.NUM_DIGITS(1), .SEG_BITS(8), .CLK_DIV(1), .LATCH_CYCLES(1)) dut_b (
    .i_clk(clk), .i_reset(reset), .bus(bus_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Stream monitor: assembles bits on serial-clock rises, pops the scoreboard at each latch.
  initial begin
    logic [47:0] stream;
    logic [47:0] exp_v;
    int          bits;
    int          latch_w;
    logic        p_clk, p_latch, p_data;
    stream = '0; bits = 0; latch_w = 0;
    p_clk = 1'b0; p_latch = 1'b0; p_data = 1'b0;
    forever begin
      @(negedge clk);
      if (bus_a.o_busy !== 1'b1) begin
        bits = 0;
        stream = '0;
      end
      if (bus_a.o_serial_clk === 1'b1 && p_clk === 1'b0) begin
        stream = {stream[46:0], bus_a.o_serial_data};
        bits++;
      end
      tests++;
      if (bus_a.o_serial_data !== p_data && bus_a.o_serial_clk !== 1'b0) begin
        fails++;
        $display("FAIL data_edge: data changed with serial_clk=%b, required 0", bus_a.o_serial_clk);
      end
      tests++;
      if (bus_a.o_done === 1'b1 && bus_a.o_serial_latch === 1'b1) begin
        fails++;
        $display("FAIL done_latch_overlap: done=1 latch=1, required not both high");
      end
      if (bus_a.o_serial_latch === 1'b1 && p_latch === 1'b0) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_frame: latch with stream %h, required no latch", stream);
        end else begin
          exp_v = exp_q.pop_front();
          if (bits != 48 || stream !== exp_v) begin
            fails++;
            $display("FAIL stream: got %h (%0d bits), required %h (48 bits)", stream, bits, exp_v);
          end
        end
      end
      if (bus_a.o_serial_latch === 1'b1) begin
        latch_w++;
      end else if (p_latch === 1'b1) begin
        tests++;
        if (latch_w != 2) begin
          fails++;
          $display("FAIL latch_width: got %0d cycles, required 2", latch_w);
        end
        latch_w = 0;
      end
      p_clk   = bus_a.o_serial_clk;
      p_latch = bus_a.o_serial_latch;
      p_data  = bus_a.o_serial_data;
    end
  end

  // Drives a start pulse; returns at the sample point right after the accepting edge.
  task automatic launch(input logic [47:0] seg, input logic [5:0] blank, input logic inv);
    @(negedge clk);
    bus_a.i_segments = seg;
    bus_a.i_blank    = blank;
    bus_a.i_invert   = inv;
    bus_a.i_start    = 1'b1;
    @(negedge clk);
    bus_a.i_start    = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if ({bus_a.o_serial_data, bus_a.o_serial_clk, bus_a.o_serial_latch, bus_a.o_busy, bus_a.o_done} !== 5'b0) begin
      fails++;
      $display("FAIL reset_outputs: got %b, required 00000",
               {bus_a.o_serial_data, bus_a.o_serial_clk, bus_a.o_serial_latch, bus_a.o_busy, bus_a.o_done});
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if ({bus_a.o_serial_data, bus_a.o_serial_clk, bus_a.o_serial_latch, bus_a.o_busy, bus_a.o_done} !== 5'b0) begin
      fails++;
      $display("FAIL idle_outputs: got %b, required 00000",
               {bus_a.o_serial_data, bus_a.o_serial_clk, bus_a.o_serial_latch, bus_a.o_busy, bus_a.o_done});
    end
  endtask

  task automatic test_basic();
    int   done_n;
    int   rises;
    logic p;
    exp_q.push_back(PAT);
    launch(PAT, 6'b0, 1'b0);
    tests++;
    if (bus_a.o_busy !== 1'b1 || bus_a.o_serial_clk !== 1'b0) begin
      fails++;
      $display("FAIL load_state: busy=%b sclk=%b, required busy=1 sclk=0", bus_a.o_busy, bus_a.o_serial_clk);
    end
    done_n = -1; rises = 0; p = 1'b0;
    for (int n = 1; n < 450; n++) begin
      @(negedge clk);
      if (n == 5) begin
        bus_a.i_segments = {$urandom, 16'h1234};
        bus_a.i_invert   = 1'b1;
        bus_a.i_blank    = 6'b101010;
        bus_a.i_start    = 1'b1;
      end
      if (bus_a.o_serial_clk === 1'b1 && p === 1'b0) rises++;
      p = bus_a.o_serial_clk;
      if (bus_a.o_done === 1'b1) begin
        done_n = n;
        break;
      end
    end
    bus_a.i_start = 1'b0;
    tests++;
    if (done_n != 387) begin
      fails++;
      $display("FAIL basic_done_cycle: got %0d, required 387", done_n);
    end
    tests++;
    if (rises != 48) begin
      fails++;
      $display("FAIL basic_sclk_rises: got %0d, required 48", rises);
    end
    @(negedge clk);
    tests++;
    if (bus_a.o_done !== 1'b0 || bus_a.o_busy !== 1'b0) begin
      fails++;
      $display("FAIL done_pulse: done=%b busy=%b, required 0 0", bus_a.o_done, bus_a.o_busy);
    end
    repeat (3) @(negedge clk);
    tests++;
    if (bus_a.o_busy !== 1'b0) begin
      fails++;
      $display("FAIL start_while_busy: busy=%b, required 0", bus_a.o_busy);
    end
  endtask

  task automatic test_blank_invert();
    int done_n;
    exp_q.push_back(~48'hFC60DAF26600);
    launch(PAT, 6'b000001, 1'b1);
    done_n = -1;
    for (int n = 1; n < 450; n++) begin
      @(negedge clk);
      if (bus_a.o_done === 1'b1) begin
        done_n = n;
        break;
      end
    end
    tests++;
    if (done_n != 387) begin
      fails++;
      $display("FAIL blank_done_cycle: got %0d, required 387", done_n);
    end
    bus_a.i_invert = 1'b0;
    bus_a.i_blank  = 6'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_start_disabled();
    int busy_seen;
    @(negedge clk);
    bus_a.i_en    = 1'b0;
    bus_a.i_start = 1'b1;
    repeat (2) @(negedge clk);
    bus_a.i_start = 1'b0;
    bus_a.i_en    = 1'b1;
    busy_seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus_a.o_busy === 1'b1) busy_seen++;
    end
    tests++;
    if (busy_seen != 0) begin
      fails++;
      $display("FAIL start_en_low: busy for %0d cycles, required 0", busy_seen);
    end
  endtask

  task automatic test_freeze();
    int         done_n;
    int         bad;
    logic [4:0] snap;
    logic [4:0] cur;
    exp_q.push_back(PAT);
    launch(PAT, 6'b0, 1'b0);
    done_n = -1; bad = 0; snap = '0;
    for (int n = 1; n < 460; n++) begin
      @(negedge clk);
      cur = {bus_a.o_serial_data, bus_a.o_serial_clk, bus_a.o_serial_latch, bus_a.o_busy, bus_a.o_done};
      if (n == 164) begin
        snap = cur;
        bus_a.i_en = 1'b0;
      end else if (n > 164 && n <= 174) begin
        if (cur !== snap) bad++;
        if (n == 174) bus_a.i_en = 1'b1;
      end
      if (bus_a.o_done === 1'b1) begin
        done_n = n;
        break;
      end
    end
    bus_a.i_en = 1'b1;
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL freeze_outputs: %0d changed samples, required 0", bad);
    end
    tests++;
    if (done_n != 397) begin
      fails++;
      $display("FAIL freeze_done_cycle: got %0d, required 397", done_n);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int ndone;
    int first_n;
    int second_n;
    int third_n;
    // Frames accepted at edges 0, 389 and 778 while start stays high.
    repeat (3) exp_q.push_back(PAT);
    @(negedge clk);
    bus_a.i_segments = PAT;
    bus_a.i_start    = 1'b1;
    @(negedge clk);
    ndone = 0; first_n = -1; second_n = -1; third_n = -1;
    for (int n = 1; n < 1000; n++) begin
      @(negedge clk);
      if (bus_a.o_done === 1'b1) begin
        ndone++;
        if (ndone == 1) first_n = n;
        if (ndone == 2) second_n = n;
      end
    end
    bus_a.i_start = 1'b0;
    for (int n = 1000; n < 1300; n++) begin
      @(negedge clk);
      if (bus_a.o_done === 1'b1) begin
        third_n = n;
        break;
      end
    end
    tests++;
    if (ndone != 2) begin
      fails++;
      $display("FAIL b2b_count: got %0d frames in window, required 2", ndone);
    end
    tests++;
    if (first_n != 387 || second_n != 776) begin
      fails++;
      $display("FAIL b2b_timing: got %0d/%0d, required 387/776", first_n, second_n);
    end
    tests++;
    if (third_n != 1165) begin
      fails++;
      $display("FAIL b2b_tail: got %0d, required 1165", third_n);
    end
    repeat (3) @(negedge clk);
    tests++;
    if (exp_q.size() != 0 || bus_a.o_busy !== 1'b0) begin
      fails++;
      $display("FAIL b2b_drain: %0d frames pending busy=%b, required 0 0", exp_q.size(), bus_a.o_busy);
    end
  endtask

  task automatic test_reset_mid_frame();
    int done_seen;
    int done_n;
    launch(PAT, 6'b0, 1'b0);
    for (int n = 1; n <= 100; n++) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    tests++;
    if ({bus_a.o_serial_data, bus_a.o_serial_clk, bus_a.o_serial_latch, bus_a.o_busy, bus_a.o_done} !== 5'b0) begin
      fails++;
      $display("FAIL mid_reset_outputs: got %b, required 00000",
               {bus_a.o_serial_data, bus_a.o_serial_clk, bus_a.o_serial_latch, bus_a.o_busy, bus_a.o_done});
    end
    reset = 1'b0;
    done_seen = 0;
    repeat (400) begin
      @(negedge clk);
      if (bus_a.o_done === 1'b1 || bus_a.o_serial_latch === 1'b1 || bus_a.o_busy === 1'b1) done_seen++;
    end
    tests++;
    if (done_seen != 0) begin
      fails++;
      $display("FAIL mid_reset_abort: %0d active cycles, required 0", done_seen);
    end
    exp_q.push_back(PAT);
    launch(PAT, 6'b0, 1'b0);
    done_n = -1;
    for (int n = 1; n < 450; n++) begin
      @(negedge clk);
      if (bus_a.o_done === 1'b1) begin
        done_n = n;
        break;
      end
    end
    tests++;
    if (done_n != 387) begin
      fails++;
      $display("FAIL post_reset_done_cycle: got %0d, required 387", done_n);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_small();
    int         done_n;
    int         bits;
    int         lat;
    logic [7:0] stream;
    logic       p;
    @(negedge clk);
    bus_b.i_segments = 8'hA5;
    bus_b.i_start    = 1'b1;
    @(negedge clk);
    bus_b.i_start = 1'b0;
    done_n = -1; bits = 0; lat = 0; stream = '0; p = 1'b0;
    for (int n = 1; n < 40; n++) begin
      @(negedge clk);
      if (bus_b.o_serial_clk === 1'b1 && p === 1'b0) begin
        stream = {stream[6:0], bus_b.o_serial_data};
        bits++;
      end
      p = bus_b.o_serial_clk;
      if (bus_b.o_serial_latch === 1'b1) lat++;
      if (bus_b.o_done === 1'b1) begin
        done_n = n;
        break;
      end
    end
    tests++;
    if (done_n != 18) begin
      fails++;
      $display("FAIL small_done_cycle: got %0d, required 18", done_n);
    end
    tests++;
    if (bits != 8 || stream !== 8'hA5) begin
      fails++;
      $display("FAIL small_stream: got %h (%0d bits), required a5 (8 bits)", stream, bits);
    end
    tests++;
    if (lat != 1) begin
      fails++;
      $display("FAIL small_latch_width: got %0d, required 1", lat);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b1;
    bus_a.i_en = 1'b1; bus_a.i_start = 1'b0; bus_a.i_segments = '0;
    bus_a.i_blank = '0; bus_a.i_invert = 1'b0;
    bus_b.i_en = 1'b1; bus_b.i_start = 1'b0; bus_b.i_segments = '0;
    bus_b.i_blank = '0; bus_b.i_invert = 1'b0;
    test_reset();
    test_basic();
    test_blank_invert();
    test_start_disabled();
    test_freeze();
    test_back_to_back();
    test_reset_mid_frame();
    test_small();
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d frames never latched, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
